// File: rtl/ext_stage.sv
// Immediate / load-data extender with a 2-entry ordered skid buffer.
// Results are computed when a request is accepted; the consumer only ever sees registered state.
module ext_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5,
    localparam int OFF_W = $clog2(OUT_W / 8)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [OUT_W-1:0] in_word,
    input  logic [OFF_W-1:0] in_off,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [1:0]       out_count
);

    typedef enum logic [3:0] {
        OP_SEXT = 4'd0,
        OP_ZEXT = 4'd1,
        OP_HI0  = 4'd2,
        OP_HI1  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_LH   = 4'd6,
        OP_LHU  = 4'd7,
        OP_LW   = 4'd8
    } op_e;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    // Shift for the upper-immediate forms; both collapse to zero when IN_W == OUT_W.
    localparam int               HI_SH    = OUT_W - IN_W;
    localparam logic [OUT_W-1:0] LOW_ONES = {OUT_W{1'b1}} >> IN_W;

    entry_t      mem [2];
    entry_t      hold_q;
    entry_t      head;
    entry_t      new_entry;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    logic [OUT_W-1:0] lane;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_count = count;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Little-endian lane select: byte offset 0 is bits [7:0].
    assign lane   = in_word >> {in_off, 3'b000};
    assign lane_b = lane[7:0];
    assign lane_h = lane[15:0];

    // NOTE: every field gets a default first so no path through the case leaves a latch.
    always_comb begin
        new_entry      = '0;
        new_entry.tag  = in_tag;
        unique case (in_op)
            OP_SEXT: new_entry.data = OUT_W'($signed(in_imm));
            OP_ZEXT: new_entry.data = OUT_W'(in_imm);
            OP_HI0:  new_entry.data = OUT_W'(in_imm) << HI_SH;
            OP_HI1:  new_entry.data = (OUT_W'(in_imm) << HI_SH) | LOW_ONES;
            OP_LB:   new_entry.data = OUT_W'($signed(lane_b));
            OP_LBU:  new_entry.data = OUT_W'(lane_b);
            OP_LH: begin
                if (in_off[0]) new_entry.err  = 1'b1;
                else           new_entry.data = OUT_W'($signed(lane_h));
            end
            OP_LHU: begin
                if (in_off[0]) new_entry.err  = 1'b1;
                else           new_entry.data = OUT_W'(lane_h);
            end
            OP_LW:   new_entry.data = in_word;
            default: new_entry.err  = 1'b1;
        endcase
    end

    // When empty, outputs show the last head that was presented (zero after reset).
    assign head     = out_valid ? mem[rd_ptr] : hold_q;
    assign out_data = head.data;
    assign out_tag  = head.tag;
    assign out_err  = head.err;

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            hold_q <= '0;
        end else begin
            if (out_valid) hold_q <= mem[rd_ptr];
            if (flush) begin
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                unique case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: storage needs no reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= new_entry;
    end

endmodule

// File: tb/tb_ext_stage.sv
// Self-checking bench for ext_stage: queue-based reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_ext_stage;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;
    localparam int OFF_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [3:0]       in_op = 4'd0;
    logic [IN_W-1:0]  in_imm = '0;
    logic [OUT_W-1:0] in_word = '0;
    logic [OFF_W-1:0] in_off = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic [1:0]       out_count;

    int checks = 0;
    int errors = 0;

    ext_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_imm(in_imm),
        .in_word(in_word), .in_off(in_off), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results derived straight from the op definitions with plain arithmetic.
    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
    } ent_t;

    function automatic ent_t model_result(logic [3:0] op, logic [15:0] imm, logic [31:0] word,
                                          logic [1:0] off, logic [4:0] tag);
        ent_t        r;
        logic [31:0] v;
        int          sh;
        sh     = 8 * int'(off);
        r.tag  = tag;
        r.err  = 1'b0;
        r.data = 32'h0;
        case (op)
            4'd0: r.data = (imm >= 16'h8000) ? 32'hFFFF0000 + {16'h0, imm} : {16'h0, imm};
            4'd1: r.data = {16'h0, imm};
            4'd2: r.data = {16'h0, imm} * 32'd65536;
            4'd3: r.data = {16'h0, imm} * 32'd65536 + 32'd65535;
            4'd4, 4'd5: begin
                v = (word >> sh) & 32'hFF;
                r.data = (op == 4'd4 && v >= 32'd128) ? v + 32'hFFFFFF00 : v;
            end
            4'd6, 4'd7: begin
                if (off % 2 != 0) r.err = 1'b1;
                else begin
                    v = (word >> sh) & 32'hFFFF;
                    r.data = (op == 4'd6 && v >= 32'h8000) ? v + 32'hFFFF0000 : v;
                end
            end
            4'd8: r.data = word;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    ent_t mq[$];
    ent_t last_out = '{32'h0, 5'h0, 1'b0};
    ent_t exp_head;
    int   m_size;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            last_out = '{32'h0, 5'h0, 1'b0};
        end else begin
            m_size = mq.size();
            if (m_size > 0) last_out = mq[0];
            if (flush) mq.delete();
            else begin
                if (m_size > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && m_size < 2)
                    mq.push_back(model_result(in_op, in_imm, in_word, in_off, in_tag));
            end
        end
    end

    always @(negedge clk) begin
        exp_head = (mq.size() > 0) ? mq[0] : last_out;
        check("model in_ready", 32'(in_ready), 32'(mq.size() < 2));
        check("model out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("model out_count", 32'(out_count), 32'(mq.size()));
        check("model out_data", out_data, exp_head.data);
        check("model out_tag", 32'(out_tag), 32'(exp_head.tag));
        check("model out_err", 32'(out_err), 32'(exp_head.err));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Push one request into an empty stage, check the head literally, then drain it.
    task automatic single(string name, logic [3:0] op, logic [15:0] imm, logic [31:0] word,
                          logic [1:0] off, logic [4:0] tag, logic [31:0] ed, logic ee);
        in_valid = 1'b1; in_op = op; in_imm = imm; in_word = word; in_off = off; in_tag = tag;
        cyc();
        in_valid = 1'b0;
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check({name, " data"}, out_data, ed);
        check({name, " err"}, 32'(out_err), 32'(ee));
        check({name, " tag"}, 32'(out_tag), 32'(tag));
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check({name, " drained"}, 32'(out_count), 32'd0);
    endtask

    initial begin
        #2 reset = 1'b0;
        cyc();
        cyc();
        check("reset count", 32'(out_count), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", out_data, 32'h0);
        check("reset out_tag", 32'(out_tag), 32'd0);
        check("reset out_err", 32'(out_err), 32'd0);
        reset = 1'b1;
        cyc();

        single("sext", 4'd0, 16'h8001, 32'h0, 2'd0, 5'd1, 32'hFFFF8001, 1'b0);
        single("zext", 4'd1, 16'h8001, 32'h0, 2'd0, 5'd2, 32'h00008001, 1'b0);
        single("hi0", 4'd2, 16'h1234, 32'h0, 2'd0, 5'd3, 32'h12340000, 1'b0);
        single("hi1", 4'd3, 16'h1234, 32'h0, 2'd0, 5'd4, 32'h1234FFFF, 1'b0);
        single("lb off0", 4'd4, 16'h0, 32'h80FF7F01, 2'd0, 5'd5, 32'h00000001, 1'b0);
        single("lb off1", 4'd4, 16'h0, 32'h80FF7F01, 2'd1, 5'd6, 32'h0000007F, 1'b0);
        single("lb off2", 4'd4, 16'h0, 32'h80FF7F01, 2'd2, 5'd7, 32'hFFFFFFFF, 1'b0);
        single("lbu off3", 4'd5, 16'h0, 32'h80FF7F01, 2'd3, 5'd8, 32'h00000080, 1'b0);
        single("lh off2", 4'd6, 16'h0, 32'h80001234, 2'd2, 5'd9, 32'hFFFF8000, 1'b0);
        single("lhu off2", 4'd7, 16'h0, 32'h80001234, 2'd2, 5'd10, 32'h00008000, 1'b0);
        single("lhu off1", 4'd7, 16'h0, 32'h80001234, 2'd1, 5'd11, 32'h00000000, 1'b1);
        single("lh off3", 4'd6, 16'h0, 32'h80001234, 2'd3, 5'd12, 32'h00000000, 1'b1);
        single("lw", 4'd8, 16'h0, 32'hDEADBEEF, 2'd3, 5'd13, 32'hDEADBEEF, 1'b0);
        single("illegal", 4'd12, 16'hFFFF, 32'hFFFFFFFF, 2'd0, 5'h1A, 32'h00000000, 1'b1);

        // Back-pressure: third request must wait until the full buffer opens.
        out_ready = 1'b0; in_valid = 1'b1; in_op = 4'd1;
        in_tag = 5'd1; in_imm = 16'h0011; cyc();
        in_tag = 5'd2; in_imm = 16'h0022; cyc();
        in_tag = 5'd3; in_imm = 16'h0033; cyc();
        check("bp full count", 32'(out_count), 32'd2);
        check("bp in_ready", 32'(in_ready), 32'd0);
        check("bp head tag1", 32'(out_tag), 32'd1);
        check("bp head data1", out_data, 32'h00000011);
        cyc();
        check("bp retry count", 32'(out_count), 32'd2);
        out_ready = 1'b1; cyc();
        check("bp head tag2", 32'(out_tag), 32'd2);
        check("bp count after pop", 32'(out_count), 32'd1);
        cyc();
        check("bp head tag3", 32'(out_tag), 32'd3);
        check("bp head data3", out_data, 32'h00000033);
        in_valid = 1'b0; cyc();
        check("bp drained", 32'(out_count), 32'd0);
        check("bp hold data", out_data, 32'h00000033);
        out_ready = 1'b0;

        // Streaming: simultaneous push and pop keeps exactly one entry in flight.
        out_ready = 1'b1; in_valid = 1'b1; in_op = 4'd0; in_tag = 5'd0; in_imm = 16'h8000;
        cyc();
        for (int i = 1; i <= 10; i++) begin
            in_tag = 5'(i);
            in_imm = 16'(i * 4097);
            cyc();
            check("stream count", 32'(out_count), 32'd1);
            check("stream tag", 32'(out_tag), 32'(i));
        end
        in_valid = 1'b0; cyc();
        out_ready = 1'b0;

        // Flush with a full buffer and a request pending.
        in_valid = 1'b1; in_op = 4'd8; in_word = 32'hCAFE0001; in_tag = 5'd7; cyc();
        in_word = 32'hCAFE0002; in_tag = 5'd8; cyc();
        check("flush pre count", 32'(out_count), 32'd2);
        in_word = 32'hCAFE0003; in_tag = 5'd9; flush = 1'b1; out_ready = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush count", 32'(out_count), 32'd0);
        check("flush out_valid", 32'(out_valid), 32'd0);
        cyc();
        check("flush dropped", 32'(out_count), 32'd0);

        // Asynchronous reset in the middle of a stream.
        in_valid = 1'b1; in_op = 4'd5; in_word = 32'h11223344; in_off = 2'd1; in_tag = 5'd11; cyc();
        in_tag = 5'd12; cyc();
        in_valid = 1'b0;
        check("midrst pre count", 32'(out_count), 32'd2);
        #3 reset = 1'b0;
        #1;
        check("midrst count", 32'(out_count), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst out_data", out_data, 32'h0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        cyc();
        reset = 1'b1;
        check("post reset in_ready", 32'(in_ready), 32'd1);
        single("post reset", 4'd0, 16'h7FFF, 32'h0, 2'd0, 5'd30, 32'h00007FFF, 1'b0);

        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
